// File: rtl/flash_cache.sv
// Direct-mapped, one-word-per-line, read-only cache in front of the SPI flash controller.
// Hits answer in two cycles; misses run one flash read, fill the line and return the word.
module flash_cache #(
  parameter int unsigned INDEX_BITS = 4,
  parameter int unsigned ADDR_BITS  = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address_in,
  input  logic        sel_in,
  input  logic        read_in,
  input  logic [3:0]  write_mask_in,
  input  logic [31:0] write_value_in,
  output logic [31:0] read_value_out,
  output logic        ready_out,
  output logic [31:0] flash_address_out,
  output logic        flash_sel_out,
  output logic        flash_read_out,
  input  logic [31:0] flash_read_value_in,
  input  logic        flash_ready_in
);

  localparam int unsigned LINES    = 1 << INDEX_BITS;
  localparam int unsigned TAG_BITS = ADDR_BITS - INDEX_BITS - 2;

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StLookup = 3'd1;
  localparam logic [2:0] StFill   = 3'd2;
  localparam logic [2:0] StResp   = 3'd3;
  localparam logic [2:0] StWack   = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [ADDR_BITS-1:2]  addr_q;
  logic [31:0]           word_q;
  logic [LINES-1:0]      valid_q;

  logic [31:0]           data_mem [LINES];
  logic [TAG_BITS-1:0]   tag_mem  [LINES];
  logic [31:0]           rd_data_q;
  logic [TAG_BITS-1:0]   rd_tag_q;

  logic [INDEX_BITS-1:0] req_idx;
  logic [INDEX_BITS-1:0] line_idx;
  logic [TAG_BITS-1:0]   line_tag;
  logic                  accept_read;
  logic                  hit;
  logic                  hit_load;
  logic                  fill_done;

  // Upper address bits alias by design; write data is discarded.
  logic unused_bits;
  assign unused_bits = ^{address_in[31:ADDR_BITS], address_in[1:0], write_mask_in,
                         write_value_in};

  assign req_idx     = address_in[INDEX_BITS+1:2];
  assign line_idx    = addr_q[INDEX_BITS+1:2];
  assign line_tag    = addr_q[ADDR_BITS-1:INDEX_BITS+2];
  assign accept_read = (state_q == StIdle) && sel_in && read_in;
  assign hit         = valid_q[line_idx] && (rd_tag_q == line_tag);
  assign fill_done   = (state_q == StFill) && flash_ready_in;

  always_comb begin
    state_d  = state_q;
    hit_load = 1'b0;
    case (state_q)
      StIdle: begin
        if (sel_in) state_d = read_in ? StLookup : StWack;
      end
      StWack: state_d = StIdle;
      StLookup: begin
        if (!sel_in) begin
          state_d = StIdle;
        end else if (hit) begin
          state_d  = StResp;
          hit_load = 1'b1;
        end else begin
          state_d = StFill;
        end
      end
      // The SPI transfer always runs to completion, even if the CPU walked away.
      StFill: begin
        if (flash_ready_in) state_d = sel_in ? StResp : StIdle;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      addr_q  <= '0;
      word_q  <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept_read) addr_q <= address_in[ADDR_BITS-1:2];
      if (hit_load) begin
        word_q <= rd_data_q;
      end else if (fill_done) begin
        word_q <= flash_read_value_in;
      end
      if (fill_done) valid_q[line_idx] <= 1'b1;
    end
  end

  // Block-RAM style storage: registered read, no reset.
  always_ff @(posedge clk) begin
    if (fill_done) begin
      data_mem[line_idx] <= flash_read_value_in;
      tag_mem[line_idx]  <= line_tag;
    end
    if (accept_read) begin
      rd_data_q <= data_mem[req_idx];
      rd_tag_q  <= tag_mem[req_idx];
    end
  end

  // Reset gates the bus outputs combinationally so an interrupted fill drops select at once.
  assign flash_sel_out     = (state_q == StFill) && !reset;
  assign flash_read_out    = flash_sel_out;
  assign flash_address_out = {{(32 - ADDR_BITS){1'b0}}, addr_q, 2'b00};
  assign ready_out         = sel_in && !reset && ((state_q == StResp) || (state_q == StWack));
  assign read_value_out    = (sel_in && !reset && (state_q == StResp)) ? word_q : 32'h0;

endmodule
